spectrum_buffer: RTL and testbench
==================================

Name: spectrum_buffer

Overview:
- Double-buffered 256-bin spectrum store between the FFT magnitude stage and the graph renderer's ROM-like read port.
- Accepts one frame of magnitudes over a valid/ready stream and scales/saturates each value to display height.
- Commits the frame to a back bank, then swaps banks only on a frame-sync pulse (vertical blank), so the renderer never shows a torn frame.
- Everything runs in the pixel clock domain; any CDC happens upstream.

Parameters:
- MAG_BITS, 16, width of incoming FFT magnitude.
- DATA_BITS, 9, width of display height value (matches renderer data_value).
- SHIFT, 7, right-shift applied to magnitude before saturation.
- MAX_HEIGHT, 440, saturation ceiling (plot height in pixels).
- ADDR_BITS, 8, bin address width; NUM_BINS = 2**ADDR_BITS = 256.

Ports:
- clk_pixel in 1: sole clock.
- rst in 1: synchronous, active-high reset.
- s_valid in 1: magnitude sample valid.
- s_ready out 1: block can accept a sample.
- s_mag in MAG_BITS: FFT magnitude, bin order 0..255.
- s_last in 1: marks the final bin of a frame.
- frame_sync in 1: one-cycle pulse at start of vertical blank; swap point.
- rd_addr in ADDR_BITS: renderer read address (data_addr).
- rd_data out DATA_BITS: height of bin rd_addr, registered.
- front_bank out 1: bank currently displayed.
- swap_done out 1: one-cycle pulse on bank swap.
- frame_err out 1: one-cycle pulse on a framing error.

Behaviour:
- Reset values: s_ready=0, rd_data=0, front_bank=0, swap_done=0, frame_err=0, wr_cnt=0, state=CLEAR.
- Storage: two NUM_BINS x DATA_BITS RAMs (bank0, bank1) with a synchronous read.
  - rd_data <= front_bank RAM[rd_addr] on every clock. Read latency is exactly 1 cycle.
- Scaling (combinational on s_mag):
  - h = s_mag >> SHIFT.
  - height = (h > MAX_HEIGHT) ? MAX_HEIGHT : h[DATA_BITS-1:0].
  - The compare uses full width, so no truncation before the compare.
- States:
  - CLEAR: wr_cnt counts 0..255 and writes 0 to both banks at wr_cnt. s_ready=0; rd_data forced to 0. After address 255 → FILL, wr_cnt=0. Takes 256 cycles.
  - FILL: s_ready=1. On s_valid&&s_ready, write height to the back bank (~front_bank) at wr_cnt.
    - If s_last && wr_cnt!=255: abort the frame, pulse frame_err, wr_cnt=0, stay FILL. Contents already written are ignored and overwritten by the next frame.
    - If wr_cnt==255: the write is committed. If s_last==0, also pulse frame_err. Go to PENDING, wr_cnt=0.
    - Otherwise wr_cnt++.
  - PENDING: s_ready=0; the back bank is frozen. On frame_sync: front_bank toggles, swap_done pulses next cycle, → FILL.
- frame_sync in FILL or CLEAR: ignored.
- frame_sync in the same cycle as the bin-255 write: no swap. The swap waits for the next frame_sync while in PENDING.
- Upstream stalls (s_valid low) are legal at any point mid-frame. There is no timeout.
- The front bank is never written outside CLEAR. The read port always reflects one complete committed frame.
- A synchronous rst mid-frame or in PENDING returns to CLEAR. The partial frame is discarded, front_bank=0, and the display reads 0 until a new frame is swapped in.
- Frame rate: at most one displayed update per frame_sync. Upstream producing faster is throttled by s_ready=0 (backpressure, no drops).

Decomposition:
- Shared package/header holds:
  - NUM_BINS, ADDR_BITS, DATA_BITS and MAX_HEIGHT, which must stay consistent with the renderer's plot height.
  - State encoding localparams (CLEAR, FILL, PENDING).
- One natural sub-module: spectrum_bank_ram, a single-port-write / registered-read NUM_BINS x DATA_BITS RAM, instantiated twice.
  - Bank select muxing and the FSM stay in spectrum_buffer.

Test Plan:
- Reset, then hold s_valid=0 for 300 cycles → s_ready=0 for the 256 CLEAR cycles then 1. rd_data=0 for all 256 addresses; front_bank=0.
- Stream 256 samples s_mag=bin*128 (s_last on bin 255), then frame_sync → no swap before sync, swap_done pulse after. rd_addr=10 returns 10 one cycle later; front_bank=1.
- Values s_mag=0xFFFF and s_mag=440*128+127 → both read back 440. s_mag=439*128 → 439.
- s_last asserted at bin 100 → frame_err pulse. The next 256-sample frame commits normally; the front bank is unchanged until frame_sync.
- Second full frame sent while PENDING and no frame_sync for 1000 cycles → s_ready=0 throughout and the front bank is unchanged. After frame_sync the new frame is accepted from bin 0.
- Bin-255 write coincident with frame_sync → no swap that cycle. The swap occurs on the following frame_sync; rst asserted in PENDING → CLEAR, rd_data=0.

Source files
------------

// File: rtl/spectrum_buffer_pkg.sv
// Shared constants and state encoding for the double-buffered spectrum store.
// DATA_BITS and MAX_HEIGHT must track the renderer's plot height.
package spectrum_buffer_pkg;

    localparam int MAG_BITS   = 16;
    localparam int DATA_BITS  = 9;
    localparam int SHIFT      = 7;
    localparam int MAX_HEIGHT = 440;
    localparam int ADDR_BITS  = 8;
    localparam int NUM_BINS   = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_FILL    = 2'd1,
        ST_PENDING = 2'd2
    } buf_state_t;

endpackage

// File: rtl/spectrum_bank_ram.sv
// One spectrum bank: single write port, registered read port (1-cycle latency).
// A read of the address being written returns the old contents.
module spectrum_bank_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
) (
    input  logic              clk_pixel,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk_pixel) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/spectrum_buffer.sv
// Double-buffered 256-bin spectrum store: fills the back bank from the FFT stream
// and swaps it to the renderer only on frame_sync, so no torn frame is displayed.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_CLEAR   | zeroing both banks, one address per cycle; input stalled
// ST_FILL    | accepting scaled magnitudes into the back bank
// ST_PENDING | back bank holds a complete frame; waiting for frame_sync
module spectrum_buffer
    import spectrum_buffer_pkg::*;
(
    input  logic                 clk_pixel,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [MAG_BITS-1:0]  s_mag,
    input  logic                 s_last,
    input  logic                 frame_sync,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 front_bank,
    output logic                 swap_done,
    output logic                 frame_err
);

    localparam logic [ADDR_BITS-1:0] LAST_BIN = ADDR_BITS'(NUM_BINS - 1);

    buf_state_t             state_q;
    buf_state_t             state_d;
    logic [ADDR_BITS-1:0]   wr_cnt;
    logic [ADDR_BITS-1:0]   wr_cnt_d;
    logic                   front_d;
    logic                   swap_d;
    logic                   err_d;
    logic                   we0;
    logic                   we1;
    logic [DATA_BITS-1:0]   wr_data;
    logic [MAG_BITS-1:0]    mag_shr;
    logic [DATA_BITS-1:0]   height;
    logic [DATA_BITS-1:0]   q0;
    logic [DATA_BITS-1:0]   q1;
    logic                   rd_zero;
    logic                   rd_bank;

    // Saturating compare is done at full magnitude width before narrowing.
    assign mag_shr = s_mag >> SHIFT;
    assign height  = (mag_shr > MAG_BITS'(MAX_HEIGHT)) ? DATA_BITS'(MAX_HEIGHT)
                                                       : mag_shr[DATA_BITS-1:0];

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            wr_cnt     <= '0;
            front_bank <= 1'b0;
            swap_done  <= 1'b0;
            frame_err  <= 1'b0;
            rd_zero    <= 1'b1;
            rd_bank    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt     <= wr_cnt_d;
            front_bank <= front_d;
            swap_done  <= swap_d;
            frame_err  <= err_d;
            rd_zero    <= (state_q == ST_CLEAR);
            rd_bank    <= front_bank;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt;
        front_d  = front_bank;
        swap_d   = 1'b0;
        err_d    = 1'b0;
        we0      = 1'b0;
        we1      = 1'b0;
        wr_data  = '0;
        s_ready  = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                we0 = 1'b1;
                we1 = 1'b1;
                if (wr_cnt == LAST_BIN) begin
                    wr_cnt_d = '0;
                    state_d  = ST_FILL;
                end else begin
                    wr_cnt_d = wr_cnt + ADDR_BITS'(1);
                end
            end

            ST_FILL: begin
                s_ready = 1'b1;
                wr_data = height;
                if (s_valid) begin
                    we0 = front_bank;
                    we1 = ~front_bank;
                    if (wr_cnt == LAST_BIN) begin
                        // Full count commits the frame even without s_last; that case is flagged.
                        err_d    = ~s_last;
                        wr_cnt_d = '0;
                        state_d  = ST_PENDING;
                    end else if (s_last) begin
                        err_d    = 1'b1;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt + ADDR_BITS'(1);
                    end
                end
            end

            ST_PENDING: begin
                if (frame_sync) begin
                    front_d = ~front_bank;
                    swap_d  = 1'b1;
                    state_d = ST_FILL;
                end
            end

            default: begin
                state_d  = ST_CLEAR;
                wr_cnt_d = '0;
            end
        endcase
    end

    spectrum_bank_ram #(
        .ADDR_W (ADDR_BITS),
        .DATA_W (DATA_BITS)
    ) u_bank0 (
        .clk_pixel (clk_pixel),
        .we        (we0),
        .wr_addr   (wr_cnt),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (q0)
    );

    spectrum_bank_ram #(
        .ADDR_W (ADDR_BITS),
        .DATA_W (DATA_BITS)
    ) u_bank1 (
        .clk_pixel (clk_pixel),
        .we        (we1),
        .wr_addr   (wr_cnt),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (q1)
    );

    // Bank select and blanking are registered alongside the RAM read so they align with it.
    assign rd_data = rd_zero ? '0 : (rd_bank ? q1 : q0);

endmodule

// File: tb/tb_spectrum_buffer.sv
// Self-checking bench for spectrum_buffer: read-back expectations are queued from a
// bench-side display model when an address is driven and compared one cycle later.
module tb_spectrum_buffer;

    logic       clk_pixel = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [15:0] s_mag;
    logic       s_last;
    logic       frame_sync;
    logic [7:0] rd_addr;
    logic [8:0] rd_data;
    logic       front_bank;
    logic       swap_done;
    logic       frame_err;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] frame_mag  [256];
    logic [8:0]  model_disp [256];
    logic [8:0]  model_pend [256];
    logic [8:0]  exp_q [$];
    bit          model_front;

    spectrum_buffer dut (
        .clk_pixel  (clk_pixel),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_mag      (s_mag),
        .s_last     (s_last),
        .frame_sync (frame_sync),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .front_bank (front_bank),
        .swap_done  (swap_done),
        .frame_err  (frame_err)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_height(input logic [15:0] m);
        int v;
        v = int'(m) / 128;
        if (v > 440) v = 440;
        return 9'(v);
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic read_bin(input int addr);
        rd_addr = 8'(addr);
        exp_q.push_back(model_disp[addr]);
        tick();
        check_val($sformatf("rd_data[%0d]", addr), 32'(rd_data), 32'(exp_q.pop_front()));
    endtask

    task automatic read_all();
        for (int a = 0; a < 256; a++) read_bin(a);
    endtask

    task automatic send_sample(input logic [15:0] mag, input logic last, input logic sync);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_mag = mag;
        s_last = last;
        while (!s_ready && n < 2000) begin
            tick();
            n++;
        end
        check_val("ready_wait", 32'(s_ready), 1);
        frame_sync = sync;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic send_frame(input int nbins, input bit sync_last);
        for (int i = 0; i < nbins; i++) begin
            send_sample(frame_mag[i], (i == nbins - 1), sync_last && (i == nbins - 1));
            check_val("frame_err", 32'(frame_err), 32'((i == nbins - 1) && (nbins != 256)));
        end
        if (nbins == 256)
            for (int i = 0; i < 256; i++) model_pend[i] = exp_height(frame_mag[i]);
    endtask

    task automatic do_sync(input bit expect_swap);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        if (expect_swap) begin
            model_front = ~model_front;
            for (int i = 0; i < 256; i++) model_disp[i] = model_pend[i];
        end
        check_val("swap_done", 32'(swap_done), 32'(expect_swap));
        check_val("front_bank", 32'(front_bank), 32'(model_front));
        tick();
        check_val("swap_done_clr", 32'(swap_done), 0);
    endtask

    initial begin
        int zeros;
        bit seen_ready;
        bit front_moved;

        rst = 1'b1;
        s_valid = 1'b0;
        s_mag = '0;
        s_last = 1'b0;
        frame_sync = 1'b0;
        rd_addr = '0;
        model_front = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_disp[i] = '0;
            model_pend[i] = '0;
        end

        repeat (3) tick();
        check_val("rst_s_ready", 32'(s_ready), 0);
        check_val("rst_front", 32'(front_bank), 0);
        check_val("rst_swap", 32'(swap_done), 0);
        check_val("rst_err", 32'(frame_err), 0);
        check_val("rst_rd_data", 32'(rd_data), 0);
        rst = 1'b0;

        zeros = 0;
        for (int i = 0; i < 300; i++) begin
            if (!s_ready) zeros++;
            tick();
        end
        check_val("clear_cycles", 32'(zeros), 256);
        check_val("ready_after_clear", 32'(s_ready), 1);
        check_val("front_after_clear", 32'(front_bank), 0);
        read_all();

        // Frame A: heights equal bin index
        for (int i = 0; i < 256; i++) frame_mag[i] = 16'(i * 128);
        send_frame(256, 1'b0);
        repeat (5) tick();
        check_val("pre_sync_swap", 32'(swap_done), 0);
        check_val("pre_sync_front", 32'(front_bank), 0);
        read_bin(10);
        do_sync(1'b1);
        read_bin(10);
        read_bin(0);
        read_bin(255);

        // frame_sync while filling is ignored
        do_sync(1'b0);

        // Aborted frame: s_last at bin 100
        for (int i = 0; i < 101; i++) frame_mag[i] = 16'(200 * 128);
        send_frame(101, 1'b0);

        // Frame B: saturation boundaries then random
        for (int i = 0; i < 256; i++) frame_mag[i] = 16'($urandom_range(0, 65535));
        frame_mag[0] = 16'hFFFF;
        frame_mag[1] = 16'(440 * 128 + 127);
        frame_mag[2] = 16'(439 * 128);
        frame_mag[3] = 16'(441 * 128);
        frame_mag[4] = 16'(440 * 128);
        frame_mag[5] = 16'(439 * 128 + 127);
        send_frame(256, 1'b0);
        check_val("front_pending_b", 32'(front_bank), 32'(model_front));
        read_bin(10);

        // Frame C offered while B is pending: must be held off
        for (int i = 0; i < 256; i++) frame_mag[i] = 16'((255 - i) * 128 + 5);
        s_valid = 1'b1;
        s_mag = frame_mag[0];
        seen_ready = 1'b0;
        front_moved = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (s_ready) seen_ready = 1'b1;
            if (front_bank != model_front) front_moved = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check_val("pending_ready_seen", 32'(seen_ready), 0);
        check_val("pending_front_moved", 32'(front_moved), 0);
        read_bin(10);
        do_sync(1'b1);
        read_all();

        send_frame(256, 1'b0);
        do_sync(1'b1);
        read_all();

        // Frame D: frame_sync coincident with the bin-255 write
        for (int i = 0; i < 256; i++) frame_mag[i] = 16'($urandom_range(0, 65535));
        send_frame(256, 1'b1);
        check_val("coinc_swap", 32'(swap_done), 0);
        check_val("coinc_front", 32'(front_bank), 32'(model_front));
        repeat (3) tick();
        check_val("coinc_swap_later", 32'(swap_done), 0);
        read_bin(77);
        do_sync(1'b1);
        read_bin(0);
        read_bin(77);
        read_bin(200);

        // Frame E then reset while pending
        for (int i = 0; i < 256; i++) frame_mag[i] = 16'(300 * 128);
        send_frame(256, 1'b0);
        rst = 1'b1;
        tick();
        check_val("rst_pend_front", 32'(front_bank), 0);
        check_val("rst_pend_ready", 32'(s_ready), 0);
        check_val("rst_pend_rd", 32'(rd_data), 0);
        rst = 1'b0;
        model_front = 1'b0;
        for (int i = 0; i < 256; i++) model_disp[i] = '0;
        read_bin(10);
        repeat (260) tick();
        check_val("ready_after_rst", 32'(s_ready), 1);
        read_bin(10);
        read_bin(0);
        read_bin(255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
